// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg
//   Shared types and helpers for the pulse train meter.
//   - meter_state_t : FSM state encoding (IDLE, COUNT, REPORT)
//   - SAT_MAX(w)    : all-ones saturation value for a w-bit counter
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } meter_state_t;

  function automatic logic [31:0] SAT_MAX(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/edge_detect_sync.sv
// edge_detect_sync
//   Multi-flop synchronizer for an asynchronous level, followed by a
//   previous-sample flop for edge detection. Runs continuously.
// Ports
//   clock    in   1  sampling clock
//   reset_n  in   1  asynchronous active-low reset, clears all flops
//   i_sig    in   1  asynchronous input level
//   o_level  out  1  synchronized level
//   o_rise   out  1  one-cycle strobe on a synchronized 0->1 transition
//   o_fall   out  1  one-cycle strobe on a synchronized 1->0 transition
module edge_detect_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/pulse_train_meter.sv
// pulse_train_meter
//   Counts rising edges of an asynchronous pulse train over a programmable
//   window of clock cycles and presents the result on a valid/ready port.
//   Optional feature macro: PULSE_WIDTH_MEAS_EN (widest high pulse in window).
// Ports
//   clock        in   1      single clock, posedge
//   reset_n      in   1      asynchronous active-low reset
//   signal       in   1      pulse train (asynchronous)
//   start        in   1      begin a window, honoured only in IDLE
//   window       in   WIN_W  window length in cycles, 0 behaves as 1
//   busy         out  1      window in progress
//   res_valid    out  1      result available
//   res_ready    in   1      consumer accepts the result
//   pulse_count  out  CNT_W  rising edges seen (saturating)
//   overflow     out  1      an edge arrived with pulse_count already saturated
//   max_width    out  CNT_W  widest high pulse in cycles (0 without the macro)
module pulse_train_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int WIN_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             signal,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] pulse_count,
  output logic             overflow,
  output logic [CNT_W-1:0] max_width
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(SAT_MAX(CNT_W));

  logic w_level;
  logic w_rise;
  logic w_fall;

  edge_detect_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .i_sig  (signal),
    .o_level(w_level),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  meter_state_t     r_state;
  logic [WIN_W-1:0] r_timer;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             w_last;

  // Final counted cycle of the window.
  assign w_last = (r_timer == WIN_W'(1));

`ifdef PULSE_WIDTH_MEAS_EN
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_max;
  logic [CNT_W-1:0] w_width_inc;

  assign w_width_inc = (r_width == SAT) ? r_width : r_width + 1'b1;
`else
  logic w_unused_width_taps;
  assign w_unused_width_taps = w_level ^ w_fall;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
`ifdef PULSE_WIDTH_MEAS_EN
      r_width <= '0;
      r_max   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_timer <= (window == '0) ? WIN_W'(1) : window;
            r_count <= '0;
            r_ovf   <= 1'b0;
`ifdef PULSE_WIDTH_MEAS_EN
            r_width <= '0;
            r_max   <= '0;
`endif
            r_state <= COUNT;
          end
        end
        COUNT: begin
          r_timer <= r_timer - 1'b1;
          if (w_rise) begin
            if (r_count == SAT) r_ovf <= 1'b1;
            else                r_count <= r_count + 1'b1;
          end
`ifdef PULSE_WIDTH_MEAS_EN
          if (w_level) r_width <= w_width_inc;
          if (w_fall) begin
            if (r_width > r_max) r_max <= r_width;
            r_width <= '0;
          end else if (w_last && w_level) begin
            // A pulse still high when the window closes is measured as
            // truncated, including this final cycle.
            if (w_width_inc > r_max) r_max <= w_width_inc;
          end
`endif
          if (w_last) r_state <= REPORT;
        end
        REPORT: begin
          if (res_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = (r_state == COUNT);
  assign res_valid   = (r_state == REPORT);
  assign pulse_count = r_count;
  assign overflow    = r_ovf;
`ifdef PULSE_WIDTH_MEAS_EN
  assign max_width   = r_max;
`else
  assign max_width   = '0;
`endif

endmodule
